// File: rtl/dma_burst_responder.sv
// Memory-side burst responder: one read or write burst at a time onto a single-port word memory.
// Reads stream one beat per three cycles; writes pass straight through to the memory port.
module dma_burst_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           rd_req_addr,
    input  logic [LEN_WIDTH-1:0]  rd_req_len,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    output logic [DATA_WIDTH-1:0] rd_rdata,
    output logic                  rd_valid,
    output logic                  rd_last,
    input  logic                  rd_ready,
    input  logic [31:0]           wr_req_addr,
    input  logic [LEN_WIDTH-1:0]  wr_req_len,
    input  logic                  wr_req_valid,
    output logic                  wr_req_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    input  logic                  wr_last,
    output logic                  wr_ready,
    output logic [31:0]           mem_addr,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  err_wlast
);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, RD_HOLD, WR_DATA} state_t;

    state_t                  state, state_next;
    logic                    prio, prio_next;
    logic [29:0]             base, base_next;
    logic [LEN_WIDTH-1:0]    len, len_next;
    logic [LEN_WIDTH-1:0]    beat, beat_next;
    logic [DATA_WIDTH-1:0]   rd_rdata_next;
    logic                    rd_valid_next;
    logic                    rd_last_next;
    logic                    err_wlast_next;
    logic [29:0]             word_addr;
    logic                    at_last;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^{rd_req_addr[1:0], wr_req_addr[1:0]};
    assign word_addr        = base + 30'(beat);
    assign at_last          = (beat == len);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= 1'b0;
            base      <= '0;
            len       <= '0;
            beat      <= '0;
            rd_rdata  <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            err_wlast <= 1'b0;
        end else begin
            state     <= state_next;
            prio      <= prio_next;
            base      <= base_next;
            len       <= len_next;
            beat      <= beat_next;
            rd_rdata  <= rd_rdata_next;
            rd_valid  <= rd_valid_next;
            rd_last   <= rd_last_next;
            err_wlast <= err_wlast_next;
        end
    end

    // Combinational strobes are gated by rst so a mid-burst reset stops memory traffic at once.
    // prio (0 = read) only flips when both sides competed for the grant.
    always_comb begin
        state_next     = state;
        prio_next      = prio;
        base_next      = base;
        len_next       = len;
        beat_next      = beat;
        rd_rdata_next  = rd_rdata;
        rd_valid_next  = rd_valid;
        rd_last_next   = rd_last;
        err_wlast_next = 1'b0;
        rd_req_ready   = 1'b0;
        wr_req_ready   = 1'b0;
        wr_ready       = 1'b0;
        mem_ren        = 1'b0;
        mem_wen        = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    rd_req_ready = rd_req_valid & (~wr_req_valid | ~prio);
                    wr_req_ready = wr_req_valid & ~rd_req_ready;
                    if (rd_req_ready) begin
                        base_next  = rd_req_addr[31:2];
                        len_next   = rd_req_len;
                        beat_next  = '0;
                        state_next = RD_ISSUE;
                        if (wr_req_valid) prio_next = 1'b1;
                    end else if (wr_req_ready) begin
                        base_next  = wr_req_addr[31:2];
                        len_next   = wr_req_len;
                        beat_next  = '0;
                        state_next = WR_DATA;
                        if (rd_req_valid) prio_next = 1'b0;
                    end
                end
                RD_ISSUE: begin
                    mem_ren    = 1'b1;
                    mem_addr   = {word_addr, 2'b00};
                    state_next = RD_WAIT;
                end
                RD_WAIT: begin
                    rd_rdata_next = mem_rdata;
                    rd_valid_next = 1'b1;
                    rd_last_next  = at_last;
                    state_next    = RD_HOLD;
                end
                RD_HOLD: begin
                    if (rd_ready) begin
                        rd_valid_next = 1'b0;
                        rd_last_next  = 1'b0;
                        if (rd_last) begin
                            state_next = IDLE;
                        end else begin
                            beat_next  = beat + 1'b1;
                            state_next = RD_ISSUE;
                        end
                    end
                end
                WR_DATA: begin
                    wr_ready  = 1'b1;
                    mem_wen   = wr_valid;
                    mem_addr  = {word_addr, 2'b00};
                    mem_wdata = wr_data;
                    if (wr_valid) begin
                        err_wlast_next = (wr_last != at_last);
                        if (at_last) begin
                            state_next = IDLE;
                        end else begin
                            beat_next = beat + 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_burst_responder.sv
// Directed bench for dma_burst_responder with a word-memory model and read/write scoreboards.
module tb_dma_burst_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rd_req_addr;
    logic [4:0]  rd_req_len;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [31:0] rd_rdata;
    logic        rd_valid;
    logic        rd_last;
    logic        rd_ready;
    logic [31:0] wr_req_addr;
    logic [4:0]  wr_req_len;
    logic        wr_req_valid;
    logic        wr_req_ready;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_last;
    logic        wr_ready;
    logic [31:0] mem_addr;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        err_wlast;

    typedef struct packed {logic [31:0] data; logic last;} rd_exp_t;
    typedef struct packed {logic [31:0] addr; logic [31:0] data;} wr_exp_t;

    rd_exp_t     rd_exp[$];
    wr_exp_t     wr_exp[$];
    logic [31:0] mem [bit [29:0]];
    int          checks = 0;
    int          errors = 0;
    int          err_pulses = 0;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_data = 32'h0;
    logic        hold_last = 1'b0;

    always #5 clk = ~clk;

    dma_burst_responder #(.DATA_WIDTH(32), .LEN_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len), .rd_req_valid(rd_req_valid),
        .rd_req_ready(rd_req_ready), .rd_rdata(rd_rdata), .rd_valid(rd_valid),
        .rd_last(rd_last), .rd_ready(rd_ready),
        .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len), .wr_req_valid(wr_req_valid),
        .wr_req_ready(wr_req_ready), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_last(wr_last), .wr_ready(wr_ready),
        .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .err_wlast(err_wlast)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_peek(input logic [29:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Word memory with one cycle of read latency.
    initial forever begin
        @(posedge clk);
        if (mem_wen) mem[mem_addr[31:2]] = mem_wdata;
        if (mem_ren) mem_rdata <= mem_peek(mem_addr[31:2]);
    end

    // Scoreboard consumers and protocol monitors, sampled mid-cycle.
    initial begin
        rd_exp_t re;
        wr_exp_t we;
        forever begin
            @(negedge clk);
            if (rd_valid && rd_ready) begin
                if (rd_exp.size() == 0) begin
                    check_output("rd_unexpected_beat", 32'(1), 32'(0));
                end else begin
                    re = rd_exp.pop_front();
                    check_output("rd_data", rd_rdata, re.data);
                    check_output("rd_last", 32'(rd_last), 32'(re.last));
                end
            end
            if (mem_wen) begin
                if (wr_exp.size() == 0) begin
                    check_output("wr_unexpected_write", 32'(1), 32'(0));
                end else begin
                    we = wr_exp.pop_front();
                    check_output("wr_addr", mem_addr, we.addr);
                    check_output("wr_data", mem_wdata, we.data);
                end
            end
            check_output("ren_wen_exclusive", 32'(mem_ren & mem_wen), 32'(0));
            if (hold_prev && !rst) begin
                check_output("rd_hold_valid", 32'(rd_valid), 32'(1));
                check_output("rd_hold_data", rd_rdata, hold_data);
                check_output("rd_hold_last", 32'(rd_last), 32'(hold_last));
            end
            hold_prev = rd_valid && !rd_ready;
            hold_data = rd_rdata;
            hold_last = rd_last;
            if (err_wlast) err_pulses++;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits for the read grant, then queues the expected beats from the memory model.
    task automatic wait_rd_grant();
        int n = 0;
        #2;
        while (!rd_req_ready && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_output("rd_grant_seen", 32'(rd_req_ready), 32'(1));
        for (int i = 0; i <= int'(rd_req_len); i++) begin
            rd_exp.push_back('{data: mem_peek(rd_req_addr[31:2] + 30'(i)), last: (i == int'(rd_req_len))});
        end
        @(posedge clk);
        #1;
        rd_req_valid = 1'b0;
    endtask

    task automatic wait_wr_grant();
        int n = 0;
        #2;
        while (!wr_req_ready && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_output("wr_grant_seen", 32'(wr_req_ready), 32'(1));
        @(posedge clk);
        #1;
        wr_req_valid = 1'b0;
    endtask

    task automatic apply_stimulus(input int n, input logic [31:0] data0, input int last_pos,
                                  input logic [29:0] word);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = data0 + 32'(i);
            wr_last  = (i == last_pos);
            wr_exp.push_back('{addr: {word + 30'(i), 2'b00}, data: data0 + 32'(i)});
            #2;
            check_output("wr_ready_beat", 32'(wr_ready), 32'(1));
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic wait_rd_drain(input bit toggle);
        int n = 0;
        while (rd_exp.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            if (toggle) rd_ready = ~rd_ready;
            n++;
        end
        check_output("rd_drain", 32'(rd_exp.size()), 32'(0));
        rd_ready = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_rd_req_ready"}, 32'(rd_req_ready), 32'(0));
        check_output({tag, "_wr_req_ready"}, 32'(wr_req_ready), 32'(0));
        check_output({tag, "_rd_valid"}, 32'(rd_valid), 32'(0));
        check_output({tag, "_rd_last"}, 32'(rd_last), 32'(0));
        check_output({tag, "_wr_ready"}, 32'(wr_ready), 32'(0));
        check_output({tag, "_mem_ren"}, 32'(mem_ren), 32'(0));
        check_output({tag, "_mem_wen"}, 32'(mem_wen), 32'(0));
        check_output({tag, "_err_wlast"}, 32'(err_wlast), 32'(0));
        check_output({tag, "_rd_rdata"}, rd_rdata, 32'h0);
        check_output({tag, "_mem_addr"}, mem_addr, 32'h0);
    endtask

    initial begin
        int n;
        int e0;
        rst = 1'b1;
        rd_req_addr = '0; rd_req_len = '0; rd_req_valid = 1'b0; rd_ready = 1'b1;
        wr_req_addr = '0; wr_req_len = '0; wr_req_valid = 1'b0;
        wr_data = '0; wr_valid = 1'b0; wr_last = 1'b0;
        for (int i = 0; i < 8; i++) mem[30'h40 + 30'(i)] = 32'(i);
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(1);

        $display("[TB] read burst len=7 at 0x100");
        rd_req_addr = 32'h100; rd_req_len = 5'd7; rd_req_valid = 1'b1;
        wait_rd_grant();
        n = 0;
        while (!rd_valid && n < 10) begin
            tick(1);
            n++;
        end
        check_output("rd_first_latency", 32'(n), 32'(2));
        wait_rd_drain(1'b0);

        $display("[TB] write burst len=3 at 0x200");
        wr_req_addr = 32'h200; wr_req_len = 5'd3; wr_req_valid = 1'b1;
        e0 = err_pulses;
        wait_wr_grant();
        apply_stimulus(4, 32'hA0, 3, 30'h80);
        check_output("wr_idle_after_burst", 32'(wr_ready), 32'(0));
        tick(2);
        check_output("wr_err_none", 32'(err_pulses - e0), 32'(0));
        for (int i = 0; i < 4; i++) check_output("wr_mem_content", mem_peek(30'h80 + 30'(i)), 32'hA0 + 32'(i));

        $display("[TB] arbitration after reset");
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        rd_req_addr = 32'h100; rd_req_len = 5'd1; rd_req_valid = 1'b1;
        wr_req_addr = 32'h300; wr_req_len = 5'd0; wr_req_valid = 1'b1;
        #2;
        check_output("arb1_rd_ready", 32'(rd_req_ready), 32'(1));
        check_output("arb1_wr_ready", 32'(wr_req_ready), 32'(0));
        wait_rd_grant();
        tick(2);
        check_output("arb1_wr_waits", 32'(wr_req_ready), 32'(0));
        wait_rd_drain(1'b0);
        #1;
        check_output("arb1_wr_after_rd", 32'(wr_req_ready), 32'(1));
        wait_wr_grant();
        apply_stimulus(1, 32'h55, 0, 30'hC0);
        rd_req_addr = 32'h104; rd_req_len = 5'd0; rd_req_valid = 1'b1;
        wr_req_addr = 32'h304; wr_req_len = 5'd0; wr_req_valid = 1'b1;
        #2;
        check_output("arb2_wr_ready", 32'(wr_req_ready), 32'(1));
        check_output("arb2_rd_ready", 32'(rd_req_ready), 32'(0));
        wait_wr_grant();
        check_output("arb2_rd_waits", 32'(rd_req_ready), 32'(0));
        apply_stimulus(1, 32'h66, 0, 30'hC1);
        wait_rd_grant();
        wait_rd_drain(1'b0);

        $display("[TB] single beat at 0xFFFFFFFC with backpressure, then wrapping len=31");
        mem[30'h3FFFFFFF] = 32'h600DF00D;
        for (int i = 0; i < 31; i++) mem[30'(i)] = 32'h5A000000 + 32'(i);
        rd_ready = 1'b0;
        rd_req_addr = 32'hFFFFFFFC; rd_req_len = 5'd0; rd_req_valid = 1'b1;
        wait_rd_grant();
        tick(4);
        check_output("single_valid", 32'(rd_valid), 32'(1));
        check_output("single_last", 32'(rd_last), 32'(1));
        check_output("single_data", rd_rdata, 32'h600DF00D);
        tick(2);
        check_output("single_data_held", rd_rdata, 32'h600DF00D);
        rd_ready = 1'b1;
        wait_rd_drain(1'b0);
        rd_req_addr = 32'hFFFFFFFC; rd_req_len = 5'd31; rd_req_valid = 1'b1;
        wait_rd_grant();
        wait_rd_drain(1'b1);

        $display("[TB] write with early wr_last");
        wr_req_addr = 32'h400; wr_req_len = 5'd3; wr_req_valid = 1'b1;
        e0 = err_pulses;
        wait_wr_grant();
        apply_stimulus(4, 32'hB0, 1, 30'h100);
        check_output("early_last_ends_on_len", 32'(wr_ready), 32'(0));
        tick(2);
        check_output("early_last_err_pulses", 32'(err_pulses - e0), 32'(2));
        check_output("early_last_beat3", mem_peek(30'h103), 32'hB3);

        $display("[TB] reset during write beat 2");
        wr_req_addr = 32'h500; wr_req_len = 5'd7; wr_req_valid = 1'b1;
        wait_wr_grant();
        apply_stimulus(2, 32'hC0, 7, 30'h140);
        wr_valid = 1'b1; wr_data = 32'hC2; wr_last = 1'b0;
        rst = 1'b1;
        #4;
        check_output("rst_cycle_mem_wen", 32'(mem_wen), 32'(0));
        check_output("rst_cycle_wr_ready", 32'(wr_ready), 32'(0));
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        check_reset_outputs("midreset");
        rst = 1'b0;
        tick(2);
        check_output("midreset_no_write", 32'(mem.exists(30'h142)), 32'(0));
        rd_req_addr = 32'h500; rd_req_len = 5'd0; rd_req_valid = 1'b1;
        wait_rd_grant();
        wait_rd_drain(1'b0);
        check_output("wr_scoreboard_empty", 32'(wr_exp.size()), 32'(0));
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
